// File: rtl/fact_accel_pkg.sv
// Shared constants for the factorial accelerator: register map, CTRL/STATUS bit
// positions and the engine state encoding.
package fact_accel_pkg;

  localparam logic [1:0] A_N      = 2'd0;
  localparam logic [1:0] A_CTRL   = 2'd1;
  localparam logic [1:0] A_STATUS = 2'd2;
  localparam logic [1:0] A_RESULT = 2'd3;

  localparam int unsigned CT_GO       = 0;
  localparam int unsigned CT_CLR_DROP = 1;
  localparam int unsigned CT_FLUSH    = 2;

  localparam int unsigned ST_DONE     = 0;
  localparam int unsigned ST_ERR      = 1;
  localparam int unsigned ST_CMD_FULL = 2;
  localparam int unsigned ST_BUSY     = 3;
  localparam int unsigned ST_DROP     = 4;

  typedef enum logic {S_IDLE, S_MUL} state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead output and a flush that wins over push/pop.
// Pushes while full and pops while empty are ignored.
module sync_fifo #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push_c, do_pop_c;

  assign empty     = (count_q == '0);
  assign full      = (count_q == CW'(DEPTH));
  assign count     = count_q;
  assign dout      = mem_q[rd_ptr_q];
  assign do_push_c = push && !full;
  assign do_pop_c  = pop && !empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push_c) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop_c)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push_c, do_pop_c})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push_c && !flush) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/fact_accel_q.sv
// Memory-mapped factorial accelerator: command FIFO of N operands feeds an
// iterative multiply engine that posts {ovf, N!} into a result FIFO.
module fact_accel_q
  import fact_accel_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned N_W   = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic        re,
  input  logic [1:0]  a,
  input  logic [31:0] wd,
  output logic [31:0] rd
);

  localparam int unsigned RW = WIDTH + 1;
  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  state_e         state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [N_W-1:0] cnt_q, cnt_d;
  logic           ovf_q, ovf_d;
  logic           go_q, drop_q;

  logic           wr_n_c, wr_ctrl_c, flush_c, rd_res_c;
  logic           cmd_pop_c, res_push_c;
  logic [RW-1:0]  res_din_c;
  logic [PW-1:0]  prod_c;
  logic [31:0]    status_c;

  logic [N_W-1:0] cmd_dout;
  logic           cmd_empty, cmd_full;
  logic [CW-1:0]  cmd_count;
  logic [RW-1:0]  res_dout;
  logic           res_empty, res_full;
  logic [CW-1:0]  unused_res_count;
  logic           unused_wd_c;

  assign wr_n_c      = we && (a == A_N);
  assign wr_ctrl_c   = we && (a == A_CTRL);
  assign flush_c     = wr_ctrl_c && wd[CT_FLUSH];
  assign rd_res_c    = re && (a == A_RESULT);
  assign unused_wd_c = ^wd;

  sync_fifo #(.W(N_W), .DEPTH(DEPTH)) u_cmd_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (wr_n_c),
    .pop   (cmd_pop_c),
    .flush (flush_c),
    .din   (wd[N_W-1:0]),
    .dout  (cmd_dout),
    .empty (cmd_empty),
    .full  (cmd_full),
    .count (cmd_count)
  );

  sync_fifo #(.W(RW), .DEPTH(DEPTH)) u_res_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (res_push_c),
    .pop   (rd_res_c),
    .flush (flush_c),
    .din   (res_din_c),
    .dout  (res_dout),
    .empty (res_empty),
    .full  (res_full),
    .count (unused_res_count)
  );

  // Control register: go level, sticky drop flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      go_q   <= 1'b0;
      drop_q <= 1'b0;
    end else begin
      if (wr_ctrl_c) go_q <= wd[CT_GO];
      if (wr_n_c && cmd_full)                    drop_q <= 1'b1;
      else if (wr_ctrl_c && wd[CT_CLR_DROP])     drop_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  // Engine next-state; a flush overrides everything and parks in IDLE.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    cmd_pop_c  = 1'b0;
    res_push_c = 1'b0;
    prod_c     = PW'(acc_q) * PW'(cnt_q);
    res_din_c  = {ovf_q, (ovf_q ? {WIDTH{1'b1}} : acc_q)};
    unique case (state_q)
      S_IDLE: begin
        if (go_q && !cmd_empty && !res_full) begin
          cmd_pop_c = 1'b1;
          acc_d     = WIDTH'(1);
          cnt_d     = cmd_dout;
          ovf_d     = 1'b0;
          state_d   = S_MUL;
        end
      end
      S_MUL: begin
        if (cnt_q <= N_W'(1)) begin
          res_push_c = 1'b1;
          state_d    = S_IDLE;
        end else begin
          acc_d = prod_c[WIDTH-1:0];
          ovf_d = ovf_q | (|prod_c[PW-1:WIDTH]);
          cnt_d = cnt_q - N_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (flush_c) begin
      state_d    = S_IDLE;
      cmd_pop_c  = 1'b0;
      res_push_c = 1'b0;
    end
  end

  always_comb begin
    status_c              = '0;
    status_c[ST_DONE]     = !res_empty;
    status_c[ST_ERR]      = !res_empty && res_dout[WIDTH];
    status_c[ST_CMD_FULL] = cmd_full;
    status_c[ST_BUSY]     = (state_q != S_IDLE);
    status_c[ST_DROP]     = drop_q;
  end

  always_comb begin
    rd = '0;
    unique case (a)
      A_N:      rd = 32'(cmd_count);
      A_CTRL:   rd = {31'b0, go_q};
      A_STATUS: rd = status_c;
      A_RESULT: rd = res_empty ? 32'h0 : 32'(res_dout[WIDTH-1:0]);
      default:  rd = '0;
    endcase
  end

endmodule

// File: tb/tb_fact_accel_q.sv
// Scoreboard bench for fact_accel_q: expected {err, result} pairs are queued as
// operands are written and compared as results are popped over the bus.
module tb_fact_accel_q;
  import fact_accel_pkg::*;

  logic        clk = 1'b0;
  logic        rst, we, re;
  logic [1:0]  a;
  logic [31:0] wd, rd;

  int n_checks = 0;
  int n_fail   = 0;
  logic [32:0] sb[$];

  always #10 clk = ~clk;

  fact_accel_q dut (
    .clk (clk),
    .rst (rst),
    .we  (we),
    .re  (re),
    .a   (a),
    .wd  (wd),
    .rd  (rd)
  );

  function automatic logic [32:0] fact_model(input int n);
    longint unsigned f;
    f = 1;
    for (int i = 2; i <= n; i++) f = f * 64'(i);
    if (f > 64'hFFFF_FFFF) return {1'b1, 32'hFFFF_FFFF};
    return {1'b0, f[31:0]};
  endfunction

  task automatic wr(input logic [1:0] addr, input logic [31:0] data);
    @(negedge clk);
    a = addr; wd = data; we = 1'b1;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic peek(input logic [1:0] addr, output logic [31:0] data);
    a = addr;
    #1;
    data = rd;
  endtask

  task automatic pop_result(output logic [31:0] val, output logic err);
    a = A_STATUS;
    #1;
    err = rd[ST_ERR];
    a = A_RESULT; re = 1'b1;
    #1;
    val = rd;
    @(negedge clk);
    re = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      a = A_STATUS;
      #1;
      if (rd[ST_DONE] === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    logic [31:0] v;
    rst = 1'b0; we = 1'b0; re = 1'b0; a = A_N; wd = '0;
    #5;
    for (int i = 0; i < 4; i++) begin
      peek(2'(i), v);
      n_checks++;
      if (v !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_rd_a%0d: got %h expected %h", i, v, 32'h0);
      end
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    peek(A_STATUS, v);
    n_checks++;
    if (v !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_status_after_release: got %h expected %h", v, 32'h0);
    end
  endtask

  task automatic test_single;
    logic [31:0] v, val;
    logic err;
    logic [32:0] exp;
    wr(A_CTRL, 32'h1);
    wr(A_N, 32'd5);
    sb.push_back(fact_model(5));
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      peek(A_STATUS, v);
      n_checks++;
      if (v[ST_DONE] !== (i == 6) || v[ST_BUSY] !== (i < 6)) begin
        n_fail++;
        $display("FAIL latency_n5_edge%0d: status %h expected done=%0d busy=%0d",
                 i, v, (i == 6), (i < 6));
      end
    end
    pop_result(val, err);
    exp = sb.pop_front();
    n_checks++;
    if ({err, val} !== exp || val !== 32'h78) begin
      n_fail++;
      $display("FAIL single_n5: got err=%0d val=%h expected %h", err, val, exp);
    end
    peek(A_STATUS, v);
    n_checks++;
    if (v[ST_DONE] !== 1'b0) begin
      n_fail++;
      $display("FAIL single_done_after_pop: got %0d expected 0", v[ST_DONE]);
    end
  endtask

  task automatic test_queue_drop;
    int ns[4] = '{0, 1, 12, 13};
    logic [31:0] v, val;
    logic err;
    logic [32:0] exp;
    bit ok;
    wr(A_CTRL, 32'h0);
    foreach (ns[i]) begin
      wr(A_N, 32'(ns[i]));
      sb.push_back(fact_model(ns[i]));
    end
    peek(A_N, v);
    n_checks++;
    if (v !== 32'd4) begin
      n_fail++;
      $display("FAIL queue_count_go0: got %0d expected 4", v);
    end
    peek(A_STATUS, v);
    n_checks++;
    if (v !== 32'h04) begin
      n_fail++;
      $display("FAIL queue_status_full: got %h expected %h", v, 32'h04);
    end
    wr(A_N, 32'd3);
    peek(A_N, v);
    n_checks++;
    if (v !== 32'd4) begin
      n_fail++;
      $display("FAIL drop_count: got %0d expected 4", v);
    end
    peek(A_STATUS, v);
    n_checks++;
    if (v !== 32'h14) begin
      n_fail++;
      $display("FAIL drop_status: got %h expected %h", v, 32'h14);
    end
    wr(A_CTRL, 32'h2);
    peek(A_STATUS, v);
    n_checks++;
    if (v !== 32'h04) begin
      n_fail++;
      $display("FAIL drop_clear: got %h expected %h", v, 32'h04);
    end
    wr(A_CTRL, 32'h1);
    for (int i = 0; i < 4; i++) begin
      wait_done(ok);
      n_checks++;
      if (!ok) begin
        n_fail++;
        $display("FAIL drain_timeout_%0d: done never rose, expected done=1", i);
      end
      pop_result(val, err);
      exp = (sb.size() > 0) ? sb.pop_front() : 33'bx;
      n_checks++;
      if ({err, val} !== exp) begin
        n_fail++;
        $display("FAIL drain_n%0d: got err=%0d val=%h expected %h", ns[i], err, val, exp);
      end
    end
  endtask

  task automatic test_result_full;
    logic [31:0] v, val;
    logic err;
    logic [32:0] exp;
    bit ok;
    for (int n = 2; n <= 5; n++) begin
      wr(A_N, 32'(n));
      sb.push_back(fact_model(n));
    end
    repeat (30) @(negedge clk);
    wr(A_N, 32'd6); sb.push_back(fact_model(6));
    wr(A_N, 32'd7); sb.push_back(fact_model(7));
    repeat (5) @(negedge clk);
    peek(A_STATUS, v);
    n_checks++;
    if (v !== 32'h01) begin
      n_fail++;
      $display("FAIL resfull_status: got %h expected %h", v, 32'h01);
    end
    peek(A_N, v);
    n_checks++;
    if (v !== 32'd2) begin
      n_fail++;
      $display("FAIL resfull_cmd_count: got %0d expected 2", v);
    end
    pop_result(val, err);
    exp = sb.pop_front();
    n_checks++;
    if ({err, val} !== exp) begin
      n_fail++;
      $display("FAIL resfull_first: got err=%0d val=%h expected %h", err, val, exp);
    end
    peek(A_STATUS, v);
    peek(A_N, val);
    n_checks++;
    if (v[ST_BUSY] !== 1'b0 || val !== 32'd2) begin
      n_fail++;
      $display("FAIL resfull_edge_of_pop: busy=%0d count=%0d expected busy=0 count=2", v[ST_BUSY], val);
    end
    @(negedge clk);
    peek(A_STATUS, v);
    peek(A_N, val);
    n_checks++;
    if (v[ST_BUSY] !== 1'b1 || val !== 32'd1) begin
      n_fail++;
      $display("FAIL resfull_restart: busy=%0d count=%0d expected busy=1 count=1", v[ST_BUSY], val);
    end
    for (int i = 0; i < 5; i++) begin
      wait_done(ok);
      n_checks++;
      if (!ok) begin
        n_fail++;
        $display("FAIL resfull_timeout_%0d: done never rose, expected done=1", i);
      end
      pop_result(val, err);
      exp = (sb.size() > 0) ? sb.pop_front() : 33'bx;
      n_checks++;
      if ({err, val} !== exp) begin
        n_fail++;
        $display("FAIL resfull_drain_%0d: got err=%0d val=%h expected %h", i, err, val, exp);
      end
    end
  endtask

  task automatic test_flush;
    logic [31:0] v, c;
    wr(A_N, 32'd9);
    wr(A_N, 32'd4);
    peek(A_STATUS, v);
    peek(A_N, c);
    n_checks++;
    if (v[ST_BUSY] !== 1'b1 || c !== 32'd1) begin
      n_fail++;
      $display("FAIL flush_pre: busy=%0d count=%0d expected busy=1 count=1", v[ST_BUSY], c);
    end
    wr(A_CTRL, 32'h5);
    peek(A_STATUS, v);
    peek(A_N, c);
    n_checks++;
    if (v !== 32'h0 || c !== 32'd0) begin
      n_fail++;
      $display("FAIL flush_now: status=%h count=%0d expected status=0 count=0", v, c);
    end
    repeat (20) @(negedge clk);
    peek(A_STATUS, v);
    peek(A_RESULT, c);
    n_checks++;
    if (v !== 32'h0 || c !== 32'h0) begin
      n_fail++;
      $display("FAIL flush_later: status=%h result=%h expected 0 and 0", v, c);
    end
  endtask

  task automatic test_same_cycle;
    logic [31:0] v, c, val;
    logic err;
    logic [32:0] exp;
    bit ok;
    wr(A_N, 32'd4);
    sb.push_back(fact_model(4));
    wait_done(ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL same_setup_timeout: done never rose, expected done=1");
    end
    @(negedge clk);
    a = A_N; wd = 32'd3; we = 1'b1;
    sb.push_back(fact_model(3));
    @(negedge clk);
    wd = 32'd2;
    sb.push_back(fact_model(2));
    @(negedge clk);
    we = 1'b0;
    peek(A_N, c);
    peek(A_STATUS, v);
    n_checks++;
    if (c !== 32'd1 || v[ST_BUSY] !== 1'b1) begin
      n_fail++;
      $display("FAIL same_cmd_pushpop: count=%0d busy=%0d expected count=1 busy=1", c, v[ST_BUSY]);
    end
    repeat (2) @(negedge clk);
    pop_result(val, err);
    exp = sb.pop_front();
    n_checks++;
    if ({err, val} !== exp) begin
      n_fail++;
      $display("FAIL same_res_pop: got err=%0d val=%h expected %h", err, val, exp);
    end
    peek(A_N, c);
    peek(A_STATUS, v);
    peek(A_RESULT, val);
    n_checks++;
    if (c !== 32'd1 || v[ST_DONE] !== 1'b1 || v[ST_BUSY] !== 1'b0 || {1'b0, val} !== sb[0]) begin
      n_fail++;
      $display("FAIL same_res_pushpop: count=%0d status=%h head=%h expected count=1 done=1 busy=0 head=%h",
               c, v, val, sb[0]);
    end
    for (int i = 0; i < 2; i++) begin
      wait_done(ok);
      n_checks++;
      if (!ok) begin
        n_fail++;
        $display("FAIL same_drain_timeout_%0d: done never rose, expected done=1", i);
      end
      pop_result(val, err);
      exp = (sb.size() > 0) ? sb.pop_front() : 33'bx;
      n_checks++;
      if ({err, val} !== exp) begin
        n_fail++;
        $display("FAIL same_drain_%0d: got err=%0d val=%h expected %h", i, err, val, exp);
      end
    end
    repeat (10) @(negedge clk);
    peek(A_STATUS, v);
    n_checks++;
    if (v[ST_DONE] !== 1'b0) begin
      n_fail++;
      $display("FAIL same_no_duplicate: done=%0d expected 0", v[ST_DONE]);
    end
  endtask

  task automatic test_reset_midjob;
    logic [31:0] v, r, c;
    wr(A_N, 32'd7);
    wr(A_N, 32'd5);
    #2;
    rst = 1'b0;
    #1;
    peek(A_STATUS, v);
    peek(A_RESULT, r);
    peek(A_N, c);
    n_checks++;
    if (v !== 32'h0 || r !== 32'h0 || c !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_midjob: status=%h result=%h count=%0d expected all 0", v, r, c);
    end
    @(negedge clk);
    rst = 1'b1;
    peek(A_CTRL, v);
    n_checks++;
    if (v !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_go_cleared: got %h expected %h", v, 32'h0);
    end
    repeat (20) @(negedge clk);
    peek(A_STATUS, v);
    n_checks++;
    if (v !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_no_partial: status=%h expected %h", v, 32'h0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_queue_drop();
    test_result_full();
    test_flush();
    test_same_cycle();
    test_reset_midjob();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
